// File: rtl/semaforo_multi.sv
// Multi-approach traffic-light controller with pedestrian phase and maintenance flashing mode.
// Lamps, walk signal, active channel and phase code are all registered.
module semaforo_multi #(
  parameter int unsigned N_CH      = 2,
  parameter int unsigned T_VERDE   = 4,
  parameter int unsigned T_AMARELO = 2,
  parameter int unsigned T_LIMPEZA = 1,
  parameter int unsigned T_PED     = 3,
  parameter int unsigned CW        = 8,
  localparam int unsigned AW       = (N_CH > 2) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              bt,
  input  logic              modo,
  output logic [3*N_CH-1:0] luz,
  output logic              ped,
  output logic [AW-1:0]     ativo,
  output logic [2:0]        fase
);

  localparam logic [2:0] VERDE    = 3'd0;
  localparam logic [2:0] AMARELO  = 3'd1;
  localparam logic [2:0] LIMPEZA  = 3'd2;
  localparam logic [2:0] PEDESTRE = 3'd3;
  localparam logic [2:0] PISCA    = 3'd4;

  logic [2:0]        state, state_n;
  logic [CW-1:0]     cnt, cnt_n, lim;
  logic [AW-1:0]     ativo_n;
  logic              pend, pend_n;
  logic              blink, blink_n;
  logic              done;
  logic [3*N_CH-1:0] luz_n;
  logic              ped_n;

  assign fase = state;

  // State, timers and registered lamp outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= VERDE;
      cnt   <= '0;
      ativo <= '0;
      pend  <= 1'b0;
      blink <= 1'b1;
      luz   <= {{(N_CH-1){3'b100}}, 3'b001};
      ped   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ativo <= ativo_n;
      pend  <= pend_n;
      blink <= blink_n;
      luz   <= luz_n;
      ped   <= ped_n;
    end
  end

  // Next-state logic; lamps are decoded from the next state so they register alongside it
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ativo_n = ativo;
    blink_n = blink;
    pend_n  = pend;
    luz_n   = '0;
    ped_n   = 1'b0;
    lim     = '0;

    case (state)
      VERDE:    lim = CW'(T_VERDE - 1);
      AMARELO:  lim = CW'(T_AMARELO - 1);
      LIMPEZA:  lim = CW'(T_LIMPEZA - 1);
      PEDESTRE: lim = CW'(T_PED - 1);
      default:  lim = '0;
    endcase
    done = tick && (cnt == lim);

    if (modo) begin
      state_n = PISCA;
      cnt_n   = '0;
      blink_n = (state == PISCA) ? (blink ^ tick) : 1'b1;
    end else begin
      case (state)
        VERDE:    if (done) state_n = AMARELO;
        AMARELO:  if (done) state_n = LIMPEZA;
        LIMPEZA:  if (done) state_n = pend ? PEDESTRE : VERDE;
        PEDESTRE: if (done) state_n = VERDE;
        PISCA: begin
          // Park on the last channel so the first green after maintenance is channel 0
          state_n = LIMPEZA;
          ativo_n = AW'(N_CH - 1);
        end
        default:  state_n = LIMPEZA;
      endcase
      if (state_n != state) cnt_n = '0;
      else if (tick)        cnt_n = cnt + CW'(1);
      if (state_n == VERDE && state != VERDE)
        ativo_n = (ativo == AW'(N_CH - 1)) ? '0 : ativo + AW'(1);
    end

    // Requests arriving while the walk phase is entered or running are not remembered
    pend_n = (modo || state == PEDESTRE || state_n == PEDESTRE) ? 1'b0 : (pend | bt);

    for (int k = 0; k < N_CH; k++) begin
      case (state_n)
        VERDE:   luz_n[3*k +: 3] = (ativo_n == AW'(k)) ? 3'b001 : 3'b100;
        AMARELO: luz_n[3*k +: 3] = (ativo_n == AW'(k)) ? 3'b010 : 3'b100;
        PISCA:   luz_n[3*k +: 3] = blink_n ? 3'b010 : 3'b000;
        default: luz_n[3*k +: 3] = 3'b100;
      endcase
    end
    ped_n = (state_n == PEDESTRE);
  end

endmodule

// File: tb/tb_semaforo_multi.sv
// Bench for semaforo_multi: directed scenarios plus randomized run against a behavioural model.
module tb_semaforo_multi;

  localparam int N = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0, bt = 1'b0, modo = 1'b0;
  logic [5:0] luz;
  logic       ped;
  logic [0:0] ativo;
  logic [2:0] fase;

  logic       rst3 = 1'b0, tick3 = 1'b1, bt3 = 1'b0, modo3 = 1'b0;
  logic [8:0] luz3;
  logic       ped3;
  logic [1:0] ativo3;
  logic [2:0] fase3;

  int checks = 0;
  int errors = 0;

  // Behavioural model: phase, ticks elapsed in phase, active approach, request, blink
  int m_ph, m_el, m_act;
  bit m_pend, m_blink;
  int dur[4] = '{4, 2, 1, 3};

  semaforo_multi dut (
    .clk(clk), .rst(rst), .tick(tick), .bt(bt), .modo(modo),
    .luz(luz), .ped(ped), .ativo(ativo), .fase(fase)
  );

  semaforo_multi #(.N_CH(3)) dut3 (
    .clk(clk), .rst(rst3), .tick(tick3), .bt(bt3), .modo(modo3),
    .luz(luz3), .ped(ped3), .ativo(ativo3), .fase(fase3)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  function automatic void model_reset();
    m_ph = 0; m_el = 0; m_act = 0; m_pend = 0; m_blink = 1;
  endfunction

  function automatic void model_step(input bit t, input bit b, input bit m);
    int old;
    old = m_ph;
    if (m) begin
      if (m_ph != 4) m_blink = 1;
      else if (t)    m_blink = !m_blink;
      m_ph = 4;
      m_el = 0;
    end else if (m_ph == 4) begin
      m_ph = 2; m_el = 0; m_act = N - 1;
    end else if (t) begin
      m_el++;
      if (m_el == dur[m_ph]) begin
        m_el = 0;
        if (m_ph == 0)      m_ph = 1;
        else if (m_ph == 1) m_ph = 2;
        else if (m_ph == 2 && m_pend) m_ph = 3;
        else begin
          m_ph = 0;
          m_act = (m_act + 1) % N;
        end
      end
    end
    if (m || old == 3 || m_ph == 3) m_pend = 0;
    else if (b) m_pend = 1;
  endfunction

  function automatic logic [5:0] exp_luz();
    logic [5:0] r;
    for (int k = 0; k < N; k++) begin
      case (m_ph)
        0: r[3*k +: 3] = (k == m_act) ? 3'b001 : 3'b100;
        1: r[3*k +: 3] = (k == m_act) ? 3'b010 : 3'b100;
        4: r[3*k +: 3] = m_blink ? 3'b010 : 3'b000;
        default: r[3*k +: 3] = 3'b100;
      endcase
    end
    return r;
  endfunction

  task automatic step(input bit t, input bit b, input bit m);
    tick = t; bt = b; modo = m;
    @(posedge clk);
    model_step(t, b, m);
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic do_reset();
    tick = 0; bt = 0; modo = 0;
    rst = 1'b0;
    model_reset();
    #4;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    rst = 1'b0;
    #1;
    checks++; if (fase !== 3'd0) begin errors++; $display("FAIL reset_fase got %0d exp 0", fase); end
    checks++; if (ativo !== 1'b0) begin errors++; $display("FAIL reset_ativo got %0d exp 0", ativo); end
    checks++; if (luz !== 6'b100001) begin errors++; $display("FAIL reset_luz got %b exp 100001", luz); end
    checks++; if (ped !== 1'b0) begin errors++; $display("FAIL reset_ped got %b exp 0", ped); end
    tick = 1;
    @(posedge clk); #1;
    checks++; if (luz !== 6'b100001 || fase !== 3'd0) begin
      errors++; $display("FAIL reset_hold got luz %b fase %0d exp 100001 0", luz, fase);
    end
    #3 rst = 1'b1;
    model_reset();
  endtask

  task automatic test_default_cycle();
    logic [5:0] el[8];
    logic [2:0] ef[8];
    el = '{6'b100001, 6'b100001, 6'b100001, 6'b100010, 6'b100010, 6'b100100, 6'b001100, 6'b001100};
    ef = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd0, 3'd0};
    do_reset();
    for (int e = 1; e <= 8; e++) begin
      step(1, 0, 0);
      checks++; if (luz !== el[e-1] || fase !== ef[e-1]) begin
        errors++; $display("FAIL cycle_e%0d got luz %b fase %0d exp %b %0d", e, luz, fase, el[e-1], ef[e-1]);
      end
    end
    checks++; if (ativo !== 1'b1) begin errors++; $display("FAIL cycle_ativo got %0d exp 1", ativo); end
  endtask

  task automatic test_ped_request();
    do_reset();
    step(1, 1, 0);
    for (int e = 2; e <= 17; e++) begin
      step(1, 0, 0);
      if (e >= 7 && e <= 9) begin
        checks++; if (ped !== 1'b1 || luz !== 6'b100100 || fase !== 3'd3) begin
          errors++; $display("FAIL ped_walk_e%0d got ped %b luz %b fase %0d exp 1 100100 3", e, ped, luz, fase);
        end
      end
      if (e == 10) begin
        checks++; if (ped !== 1'b0 || luz !== 6'b001100 || fase !== 3'd0) begin
          errors++; $display("FAIL ped_after got ped %b luz %b fase %0d exp 0 001100 0", ped, luz, fase);
        end
      end
    end
    checks++; if (fase !== 3'd0 || ped !== 1'b0 || luz !== 6'b100001) begin
      errors++; $display("FAIL ped_cleared got fase %0d ped %b luz %b exp 0 0 100001", fase, ped, luz);
    end
  endtask

  task automatic test_tick_gaps();
    bit pat[4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int e = 1; e <= 8; e++) begin
      step(pat[(e-1)%4], 0, 0);
      checks++; if (fase !== ((e < 8) ? 3'd0 : 3'd1)) begin
        errors++; $display("FAIL gaps_e%0d got fase %0d exp %0d", e, fase, (e < 8) ? 0 : 1);
      end
    end
  endtask

  task automatic test_pisca();
    do_reset();
    for (int e = 0; e < 4; e++) step(1, 0, 0);
    checks++; if (fase !== 3'd1) begin errors++; $display("FAIL pisca_pre got fase %0d exp 1", fase); end
    step(1, 0, 1);
    checks++; if (fase !== 3'd4 || luz !== 6'b010010) begin
      errors++; $display("FAIL pisca_entry got fase %0d luz %b exp 4 010010", fase, luz);
    end
    step(1, 0, 1);
    checks++; if (luz !== 6'b000000) begin errors++; $display("FAIL pisca_dark got %b exp 000000", luz); end
    step(0, 0, 1);
    checks++; if (luz !== 6'b000000) begin errors++; $display("FAIL pisca_hold got %b exp 000000", luz); end
    step(1, 1, 1);
    checks++; if (luz !== 6'b010010) begin errors++; $display("FAIL pisca_lit got %b exp 010010", luz); end
    step(0, 0, 0);
    checks++; if (fase !== 3'd2 || luz !== 6'b100100 || ativo !== 1'b1) begin
      errors++; $display("FAIL pisca_exit got fase %0d luz %b ativo %0d exp 2 100100 1", fase, luz, ativo);
    end
    step(1, 0, 0);
    checks++; if (fase !== 3'd0 || ativo !== 1'b0 || luz !== 6'b100001) begin
      errors++; $display("FAIL pisca_green got fase %0d ativo %0d luz %b exp 0 0 100001", fase, ativo, luz);
    end
  endtask

  task automatic test_async_reset_ped();
    do_reset();
    step(1, 1, 0);
    for (int e = 2; e <= 7; e++) step(1, 0, 0);
    checks++; if (ped !== 1'b1) begin errors++; $display("FAIL areset_pre got ped %b exp 1", ped); end
    #2 rst = 1'b0;
    #1;
    checks++; if (ped !== 1'b0 || luz !== 6'b100001 || fase !== 3'd0 || ativo !== 1'b0) begin
      errors++; $display("FAIL areset_now got ped %b luz %b fase %0d ativo %0d exp 0 100001 0 0", ped, luz, fase, ativo);
    end
    #1 rst = 1'b1;
    model_reset();
    for (int e = 1; e <= 7; e++) step(1, 0, 0);
    checks++; if (fase !== 3'd0 || ativo !== 1'b1) begin
      errors++; $display("FAIL areset_nopend got fase %0d ativo %0d exp 0 1", fase, ativo);
    end
  endtask

  task automatic test_random();
    bit t, b, m;
    m = 0;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      t = ($urandom_range(0, 9) < 7);
      b = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 39) == 0) m = !m;
      step(t, b, m);
      checks++; if (fase !== 3'(m_ph)) begin errors++; $display("FAIL rnd_fase_%0d got %0d exp %0d", i, fase, m_ph); end
      checks++; if (ativo !== 1'(m_act)) begin errors++; $display("FAIL rnd_ativo_%0d got %0d exp %0d", i, ativo, m_act); end
      checks++; if (luz !== exp_luz()) begin errors++; $display("FAIL rnd_luz_%0d got %b exp %b", i, luz, exp_luz()); end
      checks++; if (ped !== (m_ph == 3)) begin errors++; $display("FAIL rnd_ped_%0d got %b exp %b", i, ped, m_ph == 3); end
    end
  endtask

  task automatic test_nch3();
    int a, pos;
    logic [2:0] ech, efs;
    #4 rst3 = 1'b1;
    for (int e = 1; e <= 28; e++) begin
      @(posedge clk); #1;
      a = (e / 7) % 3;
      pos = e % 7;
      efs = (pos < 4) ? 3'd0 : ((pos < 6) ? 3'd1 : 3'd2);
      if (a != 2)       ech = 3'b100;
      else if (pos < 4) ech = 3'b001;
      else if (pos < 6) ech = 3'b010;
      else              ech = 3'b100;
      checks++; if (ativo3 !== 2'(a) || fase3 !== efs || ped3 !== 1'b0) begin
        errors++; $display("FAIL n3_seq_e%0d got ativo %0d fase %0d exp %0d %0d", e, ativo3, fase3, a, efs);
      end
      checks++; if (luz3[8:6] !== ech) begin
        errors++; $display("FAIL n3_ch2_e%0d got %b exp %b", e, luz3[8:6], ech);
      end
    end
  endtask

  initial begin
    model_reset();
    #1;
    test_reset();
    test_default_cycle();
    test_ped_request();
    test_tick_gaps();
    test_pisca();
    test_async_reset_ped();
    test_random();
    test_nch3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/semaforo_multi.md
SEMAFORO_MULTI -- requirements
Module: semaforo_multi

Interface
REQ-001 The module SHALL have parameter N_CH, default 2, meaning the number of traffic approaches (channels), legal range 2..8.
REQ-002 The module SHALL have parameter T_VERDE, default 4, meaning green duration in ticks (>=1).
REQ-003 The module SHALL have parameter T_AMARELO, default 2, meaning yellow duration in ticks (>=1).
REQ-004 The module SHALL have parameter T_LIMPEZA, default 1, meaning all-red clearance duration in ticks (>=1).
REQ-005 The module SHALL have parameter T_PED, default 3, meaning pedestrian-walk duration in ticks (>=1).
REQ-006 The module SHALL have parameter CW, default 8, meaning tick-counter width; CW SHALL hold the largest T_* value minus 1.
REQ-007 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-008 Port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-009 Port tick, input, 1 bit: time-base enable; timers advance only on clk edges with tick=1.
REQ-010 Port bt, input, 1 bit: pedestrian request, level-sampled every clk.
REQ-011 Port modo, input, 1 bit: 1 = maintenance flashing-yellow mode.
REQ-012 Port luz, output, 3*N_CH bits: per-channel one-hot lamp, channel k at bits [3k+2:3k]; 001 green, 010 yellow, 100 red, 000 dark.
REQ-013 Port ped, output, 1 bit: pedestrian walk lamp.
REQ-014 Port ativo, output, max(1,clog2(N_CH)) bits: index of the channel currently owning green/yellow.
REQ-015 Port fase, output, 3 bits: state code VERDE=0, AMARELO=1, LIMPEZA=2, PEDESTRE=3, PISCA=4.

Function
REQ-016 The controller SHALL be a Moore FSM with states VERDE, AMARELO, LIMPEZA, PEDESTRE, PISCA; all outputs SHALL be decoded from registered state only.
REQ-017 In VERDE, channel ativo SHALL show 001 and every other channel 100; ped=0.
REQ-018 In AMARELO, channel ativo SHALL show 010 and every other channel 100; ped=0.
REQ-019 In LIMPEZA all channels SHALL show 100, ped=0; in PEDESTRE all channels SHALL show 100, ped=1.
REQ-020 In PISCA all channels SHALL show 010 when the blink bit is 1 and 000 when 0; ped=0; blink SHALL be set to 1 on entry and toggle on every tick.
REQ-021 A counter SHALL clear on every state change and increment on tick; a timed state of duration T SHALL exit on the tick for which counter equals T-1, so each state lasts exactly T ticks.
REQ-022 Transitions: VERDE->AMARELO after T_VERDE; AMARELO->LIMPEZA after T_AMARELO; LIMPEZA->PEDESTRE after T_LIMPEZA if a request is pending, else LIMPEZA->VERDE; PEDESTRE->VERDE after T_PED.
REQ-023 On every entry to VERDE, ativo SHALL advance by one, wrapping from N_CH-1 to 0.
REQ-024 A pending-request flag SHALL set on any clk with bt=1 and clear on the edge entering PEDESTRE; bt=1 on that edge or during PEDESTRE SHALL be ignored.
REQ-025 modo=1 SHALL force PISCA on the next clk edge from any state, regardless of tick, clearing the counter and the pending flag.
REQ-026 In PISCA with modo=0 the FSM SHALL go to LIMPEZA on the next edge with ativo loaded to N_CH-1, so that the next green is channel 0.
REQ-027 With tick=0 and modo unchanged, state, counter, blink and outputs SHALL hold.
REQ-028 Unused fase codes SHALL recover to LIMPEZA on the next clk edge.

Reset
REQ-029 rst=0 SHALL immediately, without a clock, set fase=VERDE, ativo=0, counter=0, pending=0, blink=1, ped=0, luz = channel 0 at 001 and all others at 100.
REQ-030 Reset assertion mid-operation, including during PEDESTRE or PISCA, SHALL discard all timing and pending state; release SHALL take effect on the first clk edge after rst=1.

Verification
REQ-031 Defaults, tick=1, no bt: after reset, luz=100_001 for 4 clocks, 100_010 for 2, 100_100 for 1, then 001_100 with ativo=1.
REQ-032 A one-cycle bt pulse during channel 0 green results in, after LIMPEZA, 3 clocks of ped=1 with luz=100_100, then luz=001_100, pending=0.
REQ-033 tick toggling 1,0,0,1 with no other change: counter advances only on the tick=1 edges; green lasts 4 ticks regardless of the gaps.
REQ-034 modo=1 mid-AMARELO: next edge fase=4 and luz alternates 010_010 / 000_000 per tick; modo=0 then gives 1 clock of LIMPEZA, then ativo=0 with luz=100_001.
REQ-035 rst=0 asserted between clock edges during PEDESTRE: ped=0 and luz=100_001 appear with no clk edge.
REQ-036 N_CH=3: the green sequence is ativo 0,1,2,0, with luz bits [8:6] leaving 001 only after channel 2.
